mem_stage: RTL

Memory-access pipeline stage, directly downstream of the execute stage and upstream of write-back. It takes the registered execute-stage payload and issues at most one SRAM-like data request per instruction. It formats load data and collects multiply/divide responses, then registers the final result and exception state for write-back. Flushes are honoured without losing track of memory or multiply/divide transactions that are already in flight.

---
 rtl/mem_stage.sv | 237 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues one data request per instruction, formats loads,
// collects multiply/divide responses and registers the write-back payload.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   output logic        out_valid,
   input  logic        out_ready,
   input  logic        ex_flush,
   input  logic        ertn_flush,
   output logic        this_flush,
   input  logic        next_flush,
   input  logic [31:0] result,
   input  logic [31:0] PC,
   input  logic [31:0] rkd_value,
   input  logic [7:0]  mem_op,
   input  logic [2:0]  mul_op,
   input  logic [3:0]  div_op,
   input  logic        res_from_mem,
   input  logic        res_from_mul,
   input  logic        res_from_div,
   input  logic        res_from_csr,
   input  logic        gr_we,
   input  logic        mem_we,
   input  logic [4:0]  dest,
   input  logic        has_exception,
   input  logic [5:0]  ecode,
   input  logic [8:0]  esubcode,
   input  logic [31:0] exception_maddr,
   input  logic        ertn,
   input  logic        rdcntid,
   output logic        data_sram_req,
   output logic        data_sram_wr,
   output logic [1:0]  data_sram_size,
   output logic [31:0] data_sram_addr,
   output logic [3:0]  data_sram_wstrb,
   output logic [31:0] data_sram_wdata,
   input  logic        data_sram_addr_ok,
   input  logic        data_sram_data_ok,
   input  logic [31:0] data_sram_rdata,
   input  logic        from_mul_resp_valid,
   output logic        to_mul_resp_ready,
   input  logic [63:0] mul_result,
   input  logic        from_div_resp_valid,
   output logic        to_div_resp_ready,
   input  logic [31:0] quotient,
   input  logic [31:0] remainder,
   output logic [31:0] result_out_wire,
   output logic        mem_blocking,
   output logic [31:0] result_out,
   output logic [31:0] PC_out,
   output logic        gr_we_out,
   output logic [4:0]  dest_out,
   output logic        res_from_csr_out,
   output logic        has_exception_out,
   output logic [5:0]  ecode_out,
   output logic [8:0]  esubcode_out,
   output logic [31:0] exception_maddr_out,
   output logic        ertn_out,
   output logic        rdcntid_out
);

   typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, CANCEL} mem_state_t;

   mem_state_t  state, state_next;
   logic        flush, kill, has_mem, access;
   logic        ready_go, leave, resp_now, mem_ok;
   logic        mul_drop, div_drop, mul_cur_fire, div_cur_fire, mul_ok, div_ok;
   logic [31:0] ld_buf, ld_word, ld_value, mul_value, div_value;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   assign flush      = ex_flush | ertn_flush;
   assign this_flush = in_valid & (has_exception | ertn | next_flush);
   assign kill       = flush | this_flush;
   assign has_mem    = |mem_op;
   assign access     = in_valid & has_mem & !this_flush & !flush;
   assign leave      = in_valid & ready_go & out_ready;

   // A request may be issued straight from IDLE so a zero-wait grant costs no extra cycle.
   assign data_sram_req = ((state == IDLE) & access) | ((state == REQ) & !kill);
   assign resp_now      = (data_sram_req & data_sram_addr_ok & data_sram_data_ok)
                        | ((state == WAIT) & data_sram_data_ok);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         ld_buf <= 32'h0;
      end else begin
         state <= state_next;
         if (resp_now) ld_buf <= data_sram_rdata;
      end
   end

   // A response that is consumed in the cycle the instruction retires skips DONE,
   // otherwise the next instruction would inherit a completed access.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (access) begin
               if (data_sram_addr_ok)
                  state_next = data_sram_data_ok ? (leave ? IDLE : DONE) : WAIT;
               else
                  state_next = REQ;
            end
         end
         REQ: begin
            if (kill)
               state_next = IDLE;
            else if (data_sram_addr_ok)
               state_next = data_sram_data_ok ? (leave ? IDLE : DONE) : WAIT;
         end
         WAIT: begin
            if (data_sram_data_ok)
               state_next = (kill | leave) ? IDLE : DONE;
            else if (kill)
               state_next = CANCEL;
         end
         DONE: begin
            if (leave | kill) state_next = IDLE;
         end
         CANCEL: begin
            if (data_sram_data_ok) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign data_sram_wr   = mem_we;
   assign data_sram_addr = result;

   always_comb begin
      data_sram_size  = 2'd2;
      data_sram_wstrb = 4'h0;
      data_sram_wdata = rkd_value;
      if (mem_op[0] | mem_op[3] | mem_op[5]) data_sram_size = 2'd0;
      else if (mem_op[1] | mem_op[4] | mem_op[6]) data_sram_size = 2'd1;
      if (mem_op[5]) begin
         data_sram_wstrb = 4'b0001 << result[1:0];
         data_sram_wdata = {4{rkd_value[7:0]}};
      end else if (mem_op[6]) begin
         data_sram_wstrb = 4'b0011 << result[1:0];
         data_sram_wdata = {2{rkd_value[15:0]}};
      end else if (mem_op[7]) begin
         data_sram_wstrb = 4'hf;
      end
   end

   assign ld_word = (state == DONE) ? ld_buf : data_sram_rdata;
   assign ld_half = result[1] ? ld_word[31:16] : ld_word[15:0];

   always_comb begin
      ld_byte  = ld_word[7:0];
      ld_value = 32'h0;
      case (result[1:0])
         2'd1:    ld_byte = ld_word[15:8];
         2'd2:    ld_byte = ld_word[23:16];
         2'd3:    ld_byte = ld_word[31:24];
         default: ld_byte = ld_word[7:0];
      endcase
      if (mem_op[0])      ld_value = {{24{ld_byte[7]}}, ld_byte};
      else if (mem_op[1]) ld_value = {{16{ld_half[15]}}, ld_half};
      else if (mem_op[2]) ld_value = ld_word;
      else if (mem_op[3]) ld_value = {24'h0, ld_byte};
      else if (mem_op[4]) ld_value = {16'h0, ld_half};
   end

   assign mul_value = mul_op[0] ? mul_result[31:0] : mul_result[63:32];
   assign div_value = (div_op[0] | div_op[2]) ? quotient : remainder;

   // While a drop flag is set the next response belongs to a flushed instruction.
   assign to_mul_resp_ready = (in_valid & res_from_mul & out_ready) | mul_drop;
   assign to_div_resp_ready = (in_valid & res_from_div & out_ready) | div_drop;
   assign mul_cur_fire = in_valid & res_from_mul & from_mul_resp_valid & out_ready & !mul_drop;
   assign div_cur_fire = in_valid & res_from_div & from_div_resp_valid & out_ready & !div_drop;
   assign mul_ok = !res_from_mul | mul_cur_fire;
   assign div_ok = !res_from_div | div_cur_fire;
   assign mem_ok = !has_mem | (state == DONE) | resp_now;

   assign ready_go     = !in_valid | kill | (mem_ok & mul_ok & div_ok);
   assign in_ready     = rst & (!in_valid | (ready_go & out_ready));
   assign mem_blocking = in_valid & (res_from_mem | res_from_mul | res_from_div) & !ready_go;

   always_ff @(posedge clk) begin
      if (!rst) begin
         mul_drop <= 1'b0;
         div_drop <= 1'b0;
      end else begin
         if (in_valid & res_from_mul & (flush | leave) & !mul_cur_fire) mul_drop <= 1'b1;
         else if (mul_drop & from_mul_resp_valid)                       mul_drop <= 1'b0;
         if (in_valid & res_from_div & (flush | leave) & !div_cur_fire) div_drop <= 1'b1;
         else if (div_drop & from_div_resp_valid)                       div_drop <= 1'b0;
      end
   end

   always_comb begin
      result_out_wire = result;
      if (res_from_mem)      result_out_wire = ld_value;
      else if (res_from_mul) result_out_wire = mul_value;
      else if (res_from_div) result_out_wire = div_value;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid           <= 1'b0;
         result_out          <= 32'h0;
         PC_out              <= 32'h1c000000;
         gr_we_out           <= 1'b0;
         dest_out            <= 5'd0;
         res_from_csr_out    <= 1'b0;
         has_exception_out   <= 1'b0;
         ecode_out           <= 6'd0;
         esubcode_out        <= 9'd0;
         exception_maddr_out <= 32'h0;
         ertn_out            <= 1'b0;
         rdcntid_out         <= 1'b0;
      end else begin
         if (out_ready) out_valid <= in_valid & ready_go & !flush;
         if (leave) begin
            result_out          <= result_out_wire;
            PC_out              <= PC;
            gr_we_out           <= gr_we;
            dest_out            <= dest;
            res_from_csr_out    <= res_from_csr;
            has_exception_out   <= has_exception;
            ecode_out           <= ecode;
            esubcode_out        <= esubcode;
            exception_maddr_out <= exception_maddr;
            ertn_out            <= ertn;
            rdcntid_out         <= rdcntid;
         end
      end
   end

endmodule
